// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizes and entry layout for the reorder buffer
// Optional feature macro used by this block: ROB_CDB_BYPASS_EN
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEFAULT = 3;
    localparam int ROB_DEPTH         = 2 ** ROB_WIDTH_DEFAULT;
    localparam int REG_WIDTH         = 5;
    localparam int XLEN              = 32;

    typedef struct packed {
        logic                 busy;
        logic                 ready;
        logic [REG_WIDTH-1:0] rd;
        logic [XLEN-1:0]      val;
        logic                 mispredict;
        logic [XLEN-1:0]      target_pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_query_port.sv
// rtl/rob_query_port.sv - combinational operand lookup into the reorder buffer
// ROB_CDB_BYPASS_EN adds a same-cycle forward from the CDB.
module rob_query_port
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic [ROB_WIDTH-1:0]      query_id,
    input  logic [(2**ROB_WIDTH)-1:0] entry_ready,
    input  logic [XLEN-1:0]           entry_val [2**ROB_WIDTH],
`ifdef ROB_CDB_BYPASS_EN
    input  logic                      cdb_valid,
    input  logic [ROB_WIDTH-1:0]      cdb_rob_id,
    input  logic [XLEN-1:0]           cdb_val,
`endif
    output logic                      query_ready,
    output logic [XLEN-1:0]           query_val
);

    always_comb begin
        query_ready = entry_ready[query_id];
        query_val   = entry_val[query_id];
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_rob_id == query_id)) begin
            query_ready = 1'b1;
            query_val   = cdb_val;
        end
`endif
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer feeding the register file write port
// Optional feature macro: ROB_CDB_BYPASS_EN (CDB-to-query forwarding).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_ready,
    input  logic [31:0]          issue_val,
    output logic [ROB_WIDTH-1:0] issue_rob_id,
    output logic                 full,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob_id,
    input  logic [31:0]          cdb_val,
    input  logic                 cdb_mispredict,
    input  logic [31:0]          cdb_target_pc,
    input  logic [ROB_WIDTH-1:0] query_id1,
    input  logic [ROB_WIDTH-1:0] query_id2,
    output logic                 query_ready1,
    output logic                 query_ready2,
    output logic [31:0]          query_val1,
    output logic [31:0]          query_val2,
    output logic                 commit_valid,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic [4:0]           set_reg_id,
    output logic [31:0]          set_val,
    output logic                 flush_out,
    output logic [31:0]          flush_pc
);

    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

    rob_entry_t           ent [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 do_issue;
    logic                 do_commit;
    logic                 do_flush;
    logic [DEPTH-1:0]     entry_ready;
    logic [31:0]          entry_val [DEPTH];

    assign full         = (count == FULL_COUNT);
    assign issue_rob_id = tail;
    // flush_out blocks issue so wrong-path instructions issued alongside the flush never land
    assign do_issue     = issue_valid && !full && !flush_out;
    assign do_commit    = (count != '0) && ent[head].busy && ent[head].ready;
    assign do_flush     = do_commit && ent[head].mispredict;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            set_reg_id    <= '0;
            set_val       <= '0;
            flush_out     <= 1'b0;
            flush_pc      <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (rdy_in) begin
            flush_out    <= 1'b0;
            commit_valid <= do_commit;
            if (do_commit) begin
                commit_rob_id <= head;
                set_reg_id    <= ent[head].rd;
                set_val       <= ent[head].val;
            end else begin
                set_reg_id    <= '0;
            end
            if (do_flush) begin
                flush_out <= 1'b1;
                flush_pc  <= ent[head].target_pc;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            end else begin
                if (cdb_valid && ent[cdb_rob_id].busy) begin
                    ent[cdb_rob_id].ready      <= 1'b1;
                    ent[cdb_rob_id].val        <= cdb_val;
                    ent[cdb_rob_id].mispredict <= cdb_mispredict;
                    ent[cdb_rob_id].target_pc  <= cdb_target_pc;
                end
                if (do_issue) begin
                    ent[tail] <= '{busy: 1'b1, ready: issue_ready, rd: issue_rd,
                                   val: issue_val, mispredict: 1'b0, target_pc: '0};
                    tail      <= tail + ROB_WIDTH'(1);
                end
                // head entry is cleared last so a same-cycle writeback to it cannot revive it
                if (do_commit) begin
                    ent[head] <= '0;
                    head      <= head + ROB_WIDTH'(1);
                end
                count <= count + (ROB_WIDTH + 1)'(do_issue) - (ROB_WIDTH + 1)'(do_commit);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_ready[i] = ent[i].ready;
            entry_val[i]   = ent[i].val;
        end
    end

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query1 (
        .query_id    (query_id1),
        .entry_ready (entry_ready),
        .entry_val   (entry_val),
`ifdef ROB_CDB_BYPASS_EN
        .cdb_valid   (cdb_valid),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_val     (cdb_val),
`endif
        .query_ready (query_ready1),
        .query_val   (query_val1)
    );

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query2 (
        .query_id    (query_id2),
        .entry_ready (entry_ready),
        .entry_val   (entry_val),
`ifdef ROB_CDB_BYPASS_EN
        .cdb_valid   (cdb_valid),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_val     (cdb_val),
`endif
        .query_ready (query_ready2),
        .query_val   (query_val2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer with a program-order queue model
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid, issue_ready, cdb_valid, cdb_mispredict;
    logic [4:0]  issue_rd;
    logic [31:0] issue_val, cdb_val, cdb_target_pc;
    logic [2:0]  cdb_rob_id, query_id1, query_id2;
    logic [2:0]  issue_rob_id, commit_rob_id;
    logic        full, query_ready1, query_ready2, commit_valid, flush_out;
    logic [31:0] query_val1, query_val2, set_val, flush_pc;
    logic [4:0]  set_reg_id;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
        bit          misp;
        logic [31:0] tpc;
    } m_ent_t;

    // in-flight instructions, oldest first
    m_ent_t      q[$];
    int          m_tail;
    bit          m_cv, m_flush;
    logic [2:0]  m_cid;
    logic [4:0]  m_reg;
    logic [31:0] m_val, m_fpc;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .issue_val(issue_val), .issue_rob_id(issue_rob_id), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_val1(query_val1), .query_val2(query_val2),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .set_reg_id(set_reg_id), .set_val(set_val),
        .flush_out(flush_out), .flush_pc(flush_pc)
    );

    task automatic model_reset();
        q.delete();
        m_tail = 0; m_cv = 0; m_flush = 0; m_cid = '0;
        m_reg = '0; m_val = '0; m_fpc = '0;
    endtask

    task automatic model_edge();
        bit com, iss;
        m_ent_t e;
        if (!rdy_in) return;
        com = (q.size() > 0) && q[0].rdy;
        iss = issue_valid && (q.size() < ROB_DEPTH) && !m_flush;
        m_flush = 0;
        if (com) begin
            m_cv = 1; m_cid = q[0].id; m_reg = q[0].rd; m_val = q[0].val;
            if (q[0].misp) begin
                m_flush = 1; m_fpc = q[0].tpc;
                q.delete();
                m_tail = 0;
                return;
            end
        end else begin
            m_cv = 0; m_reg = '0;
        end
        if (cdb_valid)
            foreach (q[i])
                if (q[i].id == cdb_rob_id) begin
                    q[i].rdy = 1; q[i].val = cdb_val;
                    q[i].misp = cdb_mispredict; q[i].tpc = cdb_target_pc;
                end
        if (iss) begin
            e.id = 3'(m_tail); e.rd = issue_rd; e.rdy = issue_ready;
            e.val = issue_val; e.misp = 0; e.tpc = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % ROB_DEPTH;
        end
        if (com) void'(q.pop_front());
    endtask

    function automatic void model_query(input logic [2:0] id, output bit r, output logic [31:0] v);
        r = 0; v = '0;
        foreach (q[i]) if (q[i].id == id) begin r = q[i].rdy; v = q[i].rdy ? q[i].val : q[i].val; end
        if (BYP && cdb_valid && (cdb_rob_id == id)) begin r = 1; v = cdb_val; end
    endfunction

    task automatic idle();
        rdy_in = 1; issue_valid = 0; issue_rd = '0; issue_ready = 0; issue_val = '0;
        cdb_valid = 0; cdb_rob_id = '0; cdb_val = '0; cdb_mispredict = 0; cdb_target_pc = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        query_id1 = '0; query_id2 = '0;
        rst_in = 1;
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input bit rdy, input logic [31:0] v);
        issue_valid = 1; issue_rd = rd; issue_ready = rdy; issue_val = v;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({commit_valid, commit_rob_id, set_reg_id, set_val, flush_out, flush_pc,
             issue_rob_id, full, query_ready1} !== '0) begin
            failures++; $display("FAIL reset_state got cv=%b reg=%h val=%h fl=%b tail=%h full=%b, required all 0",
                                 commit_valid, set_reg_id, set_val, flush_out, issue_rob_id, full);
        end
        issue(5'd9, 1, 32'hDEAD_BEEF); tick(); idle(); tick();
        checks++;
        if (commit_valid !== 1'b1) begin
            failures++; $display("FAIL pre_reset_commit got %b required 1", commit_valid);
        end
        #2 rst_in = 1;
        #1;
        checks++;
        if ({commit_valid, set_reg_id, set_val, issue_rob_id, full} !== '0) begin
            failures++; $display("FAIL async_reset got cv=%b reg=%h val=%h tail=%h, required 0",
                                 commit_valid, set_reg_id, set_val, issue_rob_id);
        end
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 0;
    endtask

    task automatic test_ready_at_issue();
        do_reset();
        issue(5'd5, 1, 32'h1234); tick(); idle();
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++; $display("FAIL ready_issue_early got cv=%b required 0", commit_valid);
        end
        tick();
        checks++;
        if ({commit_valid, set_reg_id, set_val, commit_rob_id} !== {1'b1, 5'd5, 32'h1234, 3'd0}) begin
            failures++; $display("FAIL ready_issue_commit got cv=%b reg=%0d val=%h id=%0d required 1/5/1234/0",
                                 commit_valid, set_reg_id, set_val, commit_rob_id);
        end
        tick();
        checks++;
        if ({commit_valid, set_reg_id} !== {1'b0, 5'd0}) begin
            failures++; $display("FAIL commit_pulse got cv=%b reg=%0d required 0/0", commit_valid, set_reg_id);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin issue(5'(i + 1), 0, 32'(i)); tick(); end
        idle();
        checks++;
        if ({full, issue_rob_id} !== {1'b1, 3'd0}) begin
            failures++; $display("FAIL full_set got full=%b tail=%0d required 1/0", full, issue_rob_id);
        end
        issue(5'd30, 1, 32'h9999); tick(); idle();
        cdb_valid = 1; cdb_rob_id = 3'd0; cdb_val = 32'h55; tick(); idle(); tick();
        checks++;
        if ({commit_valid, commit_rob_id, set_reg_id, set_val, full} !== {1'b1, 3'd0, 5'd1, 32'h55, 1'b0}) begin
            failures++; $display("FAIL full_commit0 got cv=%b id=%0d reg=%0d val=%h full=%b required 1/0/1/55/0",
                                 commit_valid, commit_rob_id, set_reg_id, set_val, full);
        end
        issue(5'd20, 0, 32'h0); tick(); idle();
        checks++;
        if ({issue_rob_id, full} !== {3'd1, 1'b1}) begin
            failures++; $display("FAIL wrap_issue got tail=%0d full=%b required 1/1", issue_rob_id, full);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        issue(5'd3, 0, 32'h0); tick();
        issue(5'd4, 0, 32'h0); tick(); idle();
        cdb_valid = 1; cdb_rob_id = 3'd1; cdb_val = 32'h11; tick(); idle(); tick();
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++; $display("FAIL out_of_order_commit got cv=%b required 0", commit_valid);
        end
        cdb_valid = 1; cdb_rob_id = 3'd0; cdb_val = 32'h10; tick(); idle(); tick();
        checks++;
        if ({commit_valid, commit_rob_id, set_reg_id, set_val} !== {1'b1, 3'd0, 5'd3, 32'h10}) begin
            failures++; $display("FAIL in_order_first got cv=%b id=%0d reg=%0d val=%h required 1/0/3/10",
                                 commit_valid, commit_rob_id, set_reg_id, set_val);
        end
        tick();
        checks++;
        if ({commit_valid, commit_rob_id, set_reg_id, set_val} !== {1'b1, 3'd1, 5'd4, 32'h11}) begin
            failures++; $display("FAIL in_order_second got cv=%b id=%0d reg=%0d val=%h required 1/1/4/11",
                                 commit_valid, commit_rob_id, set_reg_id, set_val);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 3; i++) begin issue(5'(i + 1), 0, 32'h0); tick(); end
        idle();
        cdb_valid = 1; cdb_rob_id = 3'd0; cdb_val = 32'h44; cdb_mispredict = 1; cdb_target_pc = 32'h80;
        tick(); idle(); tick();
        checks++;
        if ({flush_out, flush_pc, commit_valid, set_reg_id, set_val, issue_rob_id, full} !==
            {1'b1, 32'h80, 1'b1, 5'd1, 32'h44, 3'd0, 1'b0}) begin
            failures++; $display("FAIL flush_commit got fl=%b pc=%h cv=%b reg=%0d val=%h tail=%0d required 1/80/1/1/44/0",
                                 flush_out, flush_pc, commit_valid, set_reg_id, set_val, issue_rob_id);
        end
        issue(5'd9, 1, 32'h99); tick(); idle();
        checks++;
        if ({flush_out, issue_rob_id} !== {1'b0, 3'd0}) begin
            failures++; $display("FAIL flush_blocks_issue got fl=%b tail=%0d required 0/0", flush_out, issue_rob_id);
        end
        issue(5'd9, 1, 32'h99); tick(); idle();
        cdb_valid = 1; cdb_rob_id = 3'd1; cdb_val = 32'h77; query_id1 = 3'd1;
        tick(); idle();
        checks++;
        if ({commit_valid, commit_rob_id, set_reg_id, query_ready1} !== {1'b1, 3'd0, 5'd9, 1'b0}) begin
            failures++; $display("FAIL post_flush got cv=%b id=%0d reg=%0d stale_q=%b required 1/0/9/0",
                                 commit_valid, commit_rob_id, set_reg_id, query_ready1);
        end
        tick();
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++; $display("FAIL ghost_commit got cv=%b required 0", commit_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        issue(5'd7, 1, 32'h77); tick();
        issue(5'd8, 1, 32'h88); tick(); idle();
        rdy_in = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({commit_valid, commit_rob_id, set_reg_id, set_val} !== {1'b1, 3'd0, 5'd7, 32'h77}) begin
                failures++; $display("FAIL stall_hold%0d got cv=%b id=%0d reg=%0d val=%h required 1/0/7/77",
                                     i, commit_valid, commit_rob_id, set_reg_id, set_val);
            end
        end
        rdy_in = 1; tick();
        checks++;
        if ({commit_valid, commit_rob_id, set_reg_id, set_val} !== {1'b1, 3'd1, 5'd8, 32'h88}) begin
            failures++; $display("FAIL stall_resume got cv=%b id=%0d reg=%0d val=%h required 1/1/8/88",
                                 commit_valid, commit_rob_id, set_reg_id, set_val);
        end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) begin issue(5'(i + 10), 0, 32'h0); tick(); end
        idle();
        cdb_valid = 1; cdb_rob_id = 3'd3; cdb_val = 32'hAA; query_id1 = 3'd3; query_id2 = 3'd2;
        #1;
        checks++;
        if ({query_ready1, query_val1, query_ready2} !== {BYP, BYP ? 32'hAA : 32'h0, 1'b0}) begin
            failures++; $display("FAIL query_same_cycle got r1=%b v1=%h r2=%b required %b/%h/0",
                                 query_ready1, query_val1, query_ready2, BYP, BYP ? 32'hAA : 32'h0);
        end
        tick(); idle();
        #1;
        checks++;
        if ({query_ready1, query_val1} !== {1'b1, 32'hAA}) begin
            failures++; $display("FAIL query_next_cycle got r1=%b v1=%h required 1/aa", query_ready1, query_val1);
        end
    endtask

    task automatic test_random();
        bit er;
        logic [31:0] ev;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rdy_in = ($urandom_range(0, 7) != 0);
            issue_valid = 1'($urandom_range(0, 1)); issue_rd = 5'($urandom);
            issue_ready = ($urandom_range(0, 3) == 0); issue_val = $urandom;
            cdb_valid = 1'($urandom_range(0, 1)); cdb_rob_id = 3'($urandom); cdb_val = $urandom;
            cdb_mispredict = ($urandom_range(0, 15) == 0); cdb_target_pc = $urandom;
            query_id1 = 3'($urandom); query_id2 = 3'($urandom);
            #1;
            model_query(query_id1, er, ev);
            checks++;
            if ({query_ready1, query_val1} !== {er, ev}) begin
                failures++; $display("FAIL rand_query1 n=%0d id=%0d got %b/%h required %b/%h",
                                     n, query_id1, query_ready1, query_val1, er, ev);
            end
            model_query(query_id2, er, ev);
            checks++;
            if ({query_ready2, query_val2} !== {er, ev}) begin
                failures++; $display("FAIL rand_query2 n=%0d id=%0d got %b/%h required %b/%h",
                                     n, query_id2, query_ready2, query_val2, er, ev);
            end
            tick();
            checks++;
            if ({commit_valid, commit_rob_id, set_reg_id, set_val} !== {m_cv, m_cid, m_reg, m_val}) begin
                failures++; $display("FAIL rand_commit n=%0d got %b/%0d/%0d/%h required %b/%0d/%0d/%h",
                                     n, commit_valid, commit_rob_id, set_reg_id, set_val, m_cv, m_cid, m_reg, m_val);
            end
            checks++;
            if ({flush_out, flush_pc} !== {m_flush, m_fpc}) begin
                failures++; $display("FAIL rand_flush n=%0d got %b/%h required %b/%h",
                                     n, flush_out, flush_pc, m_flush, m_fpc);
            end
            checks++;
            if ({full, issue_rob_id} !== {q.size() == ROB_DEPTH, 3'(m_tail)}) begin
                failures++; $display("FAIL rand_tail n=%0d got full=%b tail=%0d required %b/%0d",
                                     n, full, issue_rob_id, q.size() == ROB_DEPTH, m_tail);
            end
        end
    endtask

    initial begin
        idle();
        rst_in = 1; query_id1 = '0; query_id2 = '0;
        test_reset();
        test_ready_at_issue();
        test_full_wrap();
        test_in_order();
        test_mispredict();
        test_stall();
        test_query();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
